// File: rtl/calc_sequencer.sv
// calc_sequencer: key-entry token buffer and builder/evaluator sequencing FSM
module calc_sequencer #(
  parameter int depth = 10,
  parameter int width = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   keyValid,
  input  logic [width-1:0]       keyCode,
  output logic [width-1:0]       tokenMem [depth-1:0],
  output logic [$clog2(depth):0] tokenSize,
  output logic                   builderClear,
  output logic                   buildEval,
  output logic                   solveStart,
  input  logic                   solveDone,
  output logic                   busy,
  output logic                   resultValid,
  output logic                   fullErr,
  output logic                   keyDropped
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw + 1)'(depth);
  localparam logic [width-1:0] k_eq = width'(8'hEE);
  localparam logic [width-1:0] k_clr = width'(8'hCC);
  localparam logic [width-1:0] k_bs = width'(8'hBB);
  typedef enum logic [2:0] {IDLE, CLR, BUILD_HI, BUILD_LO, SOLVE_REQ, SOLVE_WAIT, RESULT} state_t;
  state_t state;
  logic [aw:0] cnt;
  logic is_eq, is_clr, is_bs, is_tok;
  always_comb begin
    is_eq = keyCode == k_eq;
    is_clr = keyCode == k_clr;
    is_bs = keyCode == k_bs;
    is_tok = !(is_eq || is_clr || is_bs);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      for (int i = 0; i < depth; i++) tokenMem[i] <= '0;
      tokenSize <= '0;
      cnt <= '0;
      builderClear <= 1'b0;
      buildEval <= 1'b0;
      solveStart <= 1'b0;
      busy <= 1'b0;
      resultValid <= 1'b0;
      fullErr <= 1'b0;
      keyDropped <= 1'b0;
    end else begin
      builderClear <= 1'b0;
      buildEval <= 1'b0;
      solveStart <= 1'b0;
      keyDropped <= 1'b0;
      case (state)
        IDLE: if (keyValid) begin
          if (is_clr) begin
            for (int i = 0; i < depth; i++) tokenMem[i] <= '0;
            tokenSize <= '0;
            fullErr <= 1'b0;
          end else if (is_bs) begin
            if (tokenSize != '0) tokenSize <= tokenSize - 1'b1;
            fullErr <= 1'b0;
          end else if (is_eq) begin
            if (tokenSize != '0) begin
              state <= CLR;
              builderClear <= 1'b1;
              busy <= 1'b1;
            end
          end else if (tokenSize == full_cnt) begin
            keyDropped <= 1'b1;
            fullErr <= 1'b1;
          end else begin
            tokenMem[tokenSize[aw-1:0]] <= keyCode;
            tokenSize <= tokenSize + 1'b1;
          end
        end
        CLR: begin
          cnt <= tokenSize;
          buildEval <= 1'b1;
          state <= BUILD_HI;
        end
        BUILD_HI: begin
          cnt <= cnt - 1'b1;
          state <= BUILD_LO;
        end
        // the low cycle between eval pulses lets the builder see a fresh rising edge
        BUILD_LO: if (cnt == '0) begin
          solveStart <= 1'b1;
          state <= SOLVE_REQ;
        end else begin
          buildEval <= 1'b1;
          state <= BUILD_HI;
        end
        SOLVE_REQ: state <= SOLVE_WAIT;
        SOLVE_WAIT: if (solveDone) begin
          busy <= 1'b0;
          resultValid <= 1'b1;
          state <= RESULT;
        end
        RESULT: if (keyValid && !is_eq) begin
          for (int i = 0; i < depth; i++) tokenMem[i] <= '0;
          tokenSize <= '0;
          fullErr <= 1'b0;
          resultValid <= 1'b0;
          state <= IDLE;
          if (is_tok) begin
            tokenMem[0] <= keyCode;
            tokenSize <= (aw + 1)'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if (keyValid && busy) keyDropped <= 1'b1;
    end
  end
endmodule
